// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the HMAC harness driver and its device port.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/hmac_tl_driver.sv
// Instruction-stream driven TL-UL host: issues one READ/WRITE at a time to the HMAC
// device port, with WAIT/NOP pacing, response capture and a per-transaction timeout.
module hmac_tl_driver #(
  parameter logic [31:0] BaseAddr      = 32'h0000_0000,
  parameter int unsigned AddrW         = 12,
  parameter logic [7:0]  SourceId      = 8'h00,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [1:0]           instr_op_i,
  input  logic [AddrW-1:0]     instr_addr_i,
  input  logic [31:0]          instr_data_i,
  output tlul_pkg::tl_h2d_t    tl_o,
  input  tlul_pkg::tl_d2h_t    tl_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 timeout_o,
  output logic [15:0]          txn_cnt_o,
  output logic                 busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StRsp  = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  localparam logic [1:0] OpWait  = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpRead  = 2'd2;

  localparam int unsigned    ToW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 1);

  logic [1:0]     state_q, state_d;
  logic           is_write_q, is_write_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [15:0]    wait_cnt_q, wait_cnt_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           timeout_q, timeout_d;
  logic [15:0]    txn_cnt_q, txn_cnt_d;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    to_cnt_d    = to_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = timeout_q;
    txn_cnt_d   = txn_cnt_q;

    case (state_q)
      StIdle: begin
        if (instr_valid_i) begin
          case (instr_op_i)
            OpWait: begin
              wait_cnt_d = instr_data_i[15:0];
              state_d    = StWait;
            end
            OpWrite, OpRead: begin
              is_write_d = (instr_op_i == OpWrite);
              // Word-aligned offset, 32-bit wrapping add onto the base.
              addr_d     = BaseAddr + 32'({instr_addr_i[AddrW-1:2], 2'b00});
              wdata_d    = instr_data_i;
              state_d    = StReq;
            end
            default: ;
          endcase
        end
      end
      StReq: begin
        if (tl_i.a_ready) begin
          to_cnt_d = '0;
          state_d  = StRsp;
        end
      end
      StRsp: begin
        // A response on the terminal-count cycle still counts as a completion.
        if (tl_i.d_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = tl_i.d_data;
          rsp_err_d   = tl_i.d_error;
          if (txn_cnt_q != 16'hFFFF) txn_cnt_d = txn_cnt_q + 16'd1;
          state_d     = StIdle;
        end else if (to_cnt_q == ToLast) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'h0;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (wait_cnt_q == 16'd0) state_d = StIdle;
        else wait_cnt_d = wait_cnt_q - 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wait_cnt_q  <= 16'h0;
      to_cnt_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      txn_cnt_q   <= 16'h0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      to_cnt_q    <= to_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == StReq);
    tl_o.a_opcode  = is_write_q ? tlul_pkg::PutFullData : tlul_pkg::Get;
    tl_o.a_param   = 3'h0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = SourceId;
    tl_o.a_address = addr_q;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = is_write_q ? wdata_q : 32'h0;
    tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    tl_o.d_ready   = (state_q == StRsp);
  end

  assign instr_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign timeout_o     = timeout_q;
  assign txn_cnt_o     = txn_cnt_q;

  logic unused_sigs;
  assign unused_sigs = ^{instr_addr_i[1:0], tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                         tl_i.d_source, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_hmac_tl_driver.sv
// Randomized bench for hmac_tl_driver: emulates the TL device and predicts every
// request and response from the instruction stream at transaction level.
module tb_hmac_tl_driver;

  localparam logic [31:0] Base = 32'hFFFF_FF00;
  localparam int          Tmo  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        instr_op;
  logic [11:0]       instr_addr;
  logic [31:0]       instr_data;
  tlul_pkg::tl_h2d_t tl_h;
  tlul_pkg::tl_d2h_t tl_d;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              timeout;
  logic [15:0]       txn_cnt;
  logic              busy;

  hmac_tl_driver #(
    .BaseAddr      (Base),
    .AddrW         (12),
    .SourceId      (8'h00),
    .TimeoutCycles (Tmo)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .instr_op_i    (instr_op),
    .instr_addr_i  (instr_addr),
    .instr_data_i  (instr_data),
    .tl_o          (tl_h),
    .tl_i          (tl_d),
    .rsp_valid_o   (rsp_valid),
    .rsp_data_o    (rsp_data),
    .rsp_err_o     (rsp_err),
    .timeout_o     (timeout),
    .txn_cnt_o     (txn_cnt),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state.
  int          exp_txn   = 0;
  bit          exp_to    = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_rerr  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_rw(input bit wr, input logic [11:0] off, input logic [31:0] wd,
                        input int ard, input int dvd, input logic [31:0] rd, input bit rerr);
    logic [31:0] ea;
    int          last;
    bit          ok;
    logic [31:0] r;
    ea   = Base + {20'h0, off & 12'hFFC};
    ok   = (dvd < Tmo);
    last = ok ? dvd : Tmo - 1;
    check_eq("rw_instr_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = wr ? 2'd1 : 2'd2;
    instr_addr  = off;
    instr_data  = wd;
    @(negedge clk);
    instr_valid = 1'b0;
    r           = $urandom();
    instr_data  = r;
    for (int i = 0; i <= ard; i++) begin
      check_eq("req_a_valid", tl_h.a_valid, 1);
      check_eq("req_opcode", tl_h.a_opcode, wr ? tlul_pkg::PutFullData : tlul_pkg::Get);
      check_eq("req_address", tl_h.a_address, ea);
      check_eq("req_data", tl_h.a_data, wr ? wd : 32'h0);
      check_eq("req_fixed", {tl_h.a_param, tl_h.a_size, tl_h.a_mask, tl_h.a_source},
               {3'h0, 2'd2, 4'hF, 8'h00});
      check_eq("req_user", tl_h.a_user, tlul_pkg::TL_A_USER_DEFAULT);
      check_eq("req_instr_ready", instr_ready, 0);
      check_eq("req_d_ready", tl_h.d_ready, 0);
      if (i == 0) begin
        check_eq("req_rsp_valid_low", rsp_valid, 0);
        check_eq("req_rsp_hold", {rsp_err, rsp_data}, {exp_rerr, exp_rdata});
      end
      tl_d.a_ready = (i == ard);
      @(negedge clk);
    end
    tl_d.a_ready = 1'b0;
    for (int j = 0; j <= last; j++) begin
      check_eq("rsp_d_ready", tl_h.d_ready, 1);
      check_eq("rsp_a_valid", tl_h.a_valid, 0);
      check_eq("rsp_busy", busy, 1);
      check_eq("rsp_no_pulse", rsp_valid, 0);
      if (j == dvd) begin
        tl_d.d_valid = 1'b1;
        tl_d.d_data  = rd;
        tl_d.d_error = rerr;
      end
      @(negedge clk);
    end
    tl_d.d_valid = 1'b0;
    if (ok) begin
      exp_rdata = rd;
      exp_rerr  = rerr;
      if (exp_txn < 16'hFFFF) exp_txn++;
    end else begin
      exp_rdata = 32'h0;
      exp_rerr  = 1'b1;
      exp_to    = 1'b1;
    end
    check_eq("done_rsp_valid", rsp_valid, 1);
    check_eq("done_rsp_data", rsp_data, exp_rdata);
    check_eq("done_rsp_err", rsp_err, exp_rerr);
    check_eq("done_txn_cnt", txn_cnt, exp_txn);
    check_eq("done_timeout", timeout, exp_to);
    check_eq("done_busy", busy, 0);
  endtask

  task automatic run_wait(input logic [15:0] n);
    logic [31:0] r;
    r = $urandom();
    check_eq("wait_instr_ready", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = 2'd0;
    instr_data  = {r[31:16], n};
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k <= int'(n); k++) begin
      check_eq("wait_busy", busy, 1);
      check_eq("wait_no_tl", {tl_h.a_valid, tl_h.d_ready, instr_ready}, 3'b000);
      check_eq("wait_rsp_hold", {rsp_valid, rsp_err, rsp_data}, {1'b0, exp_rerr, exp_rdata});
      @(negedge clk);
    end
    check_eq("wait_end_busy", busy, 0);
    check_eq("wait_end_ready", instr_ready, 1);
  endtask

  task automatic run_nop();
    instr_valid = 1'b1;
    instr_op    = 2'd3;
    instr_data  = $urandom();
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("nop_state", {busy, instr_ready, tl_h.a_valid, tl_h.d_ready}, 4'b0100);
    check_eq("nop_txn_cnt", txn_cnt, exp_txn);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got=expired expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int sel;
    int dvd;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 2'd3;
    instr_addr  = 12'h0;
    instr_data  = 32'h0;
    tl_d        = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_tl", {tl_h.a_valid, tl_h.d_ready}, 2'b00);
    check_eq("reset_outs", {busy, rsp_valid, rsp_err, timeout}, 4'b0000);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_txn_cnt", txn_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset_ready", instr_ready, 1);

    run_rw(1'b1, 12'h024, 32'hDEADBEEF, 0, 0, $urandom(), 1'b0);
    run_rw(1'b0, 12'h027, $urandom(), 0, 1, 32'h1234_5678, 1'b0);
    run_rw(1'b1, 12'h124, 32'hCAFE_F00D, 5, 0, $urandom(), 1'b0);
    run_rw(1'b0, 12'h3F0, $urandom(), 1, Tmo + 10, $urandom(), 1'b0);

    // Late response arriving in IDLE must be ignored.
    tl_d.d_valid = 1'b1;
    tl_d.d_data  = 32'hBAAD_0001;
    @(negedge clk);
    tl_d.d_valid = 1'b0;
    check_eq("late_d_ignored", {rsp_valid, busy, tl_h.d_ready}, 3'b000);
    check_eq("late_txn_cnt", txn_cnt, exp_txn);
    check_eq("late_rsp_hold", rsp_data, exp_rdata);

    // Response on the terminal-count cycle wins over the timeout.
    run_rw(1'b0, 12'h010, $urandom(), 0, Tmo - 1, 32'h5A5A_A5A5, 1'b1);

    run_wait(16'd3);
    run_nop();
    run_wait(16'd0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        run_wait(16'($urandom_range(0, 6)));
      end else if (op == 3) begin
        run_nop();
      end else begin
        sel = $urandom_range(0, 19);
        dvd = (sel == 0) ? Tmo + 5 : $urandom_range(0, 4);
        run_rw(op == 1, 12'($urandom()), $urandom(), $urandom_range(0, 3), dvd,
               $urandom(), 1'($urandom()));
      end
    end

    // Reset in the middle of a response wait.
    instr_valid = 1'b1;
    instr_op    = 2'd2;
    instr_addr  = 12'h040;
    @(negedge clk);
    instr_valid  = 1'b0;
    tl_d.a_ready = 1'b1;
    @(negedge clk);
    tl_d.a_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_rsp", {busy, tl_h.d_ready}, 2'b11);
    #2;
    rst          = 1'b1;
    tl_d.d_valid = 1'b1;
    tl_d.d_data  = 32'h7777_8888;
    #1;
    check_eq("async_rst_drop", {tl_h.a_valid, tl_h.d_ready, busy, rsp_valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tl_d.d_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("post_rst_quiet", {rsp_valid, busy, timeout, instr_ready}, 4'b0001);
      check_eq("post_rst_txn", txn_cnt, 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
